prefix_orient_unit: RTL and testbench

Parametrised successor to the single-cycle DNA prefix classifier. Accepts a codeword of up to N quaternary digits (2 bits each) over a valid/ready handshake, classifies its P-digit orientation prefix as clean forward, deletion-corrupted forward, clean reverse, deletion-corrupted reverse or invalid, and strips the prefix. Reverse-oriented payloads are digit-reversed serially at DPC digits per cycle before output. Sits between the read front-end and the suffix/deletion-correction stage.

---
 rtl/prefix_orient_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_prefix_orient_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_orient_unit.sv
// Classifies a codeword's orientation prefix, strips it, and digit-reverses reverse-oriented payloads (2+ceil(plen/DPC) cycles).
// Holds results under out_ready backpressure; define REVCOMP_EN to complement digits during reversal.
module prefix_orient_unit #(
  parameter int N = 100,
  parameter int P = 2,
  parameter logic [2*P-1:0] FWD_PREFIX = 4'b0100,
  parameter logic [2*P-1:0] REV_PREFIX = 4'b1011,
  parameter int DPC = 4,
  localparam int LW = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*N-1:0]  word_in,
  input  logic [LW-1:0]   word_in_len,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  word_out,
  output logic [LW-1:0]   word_out_len,
  output logic            reverse_needed,
  output logic            in_prefix,
  output logic            prefix_err,
  output logic            busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_REVERSE  = 2'd2;
  localparam logic [1:0] S_OUT      = 2'd3;

`ifdef REVCOMP_EN
  localparam logic [1:0] CMASK = 2'b01;
`else
  localparam logic [1:0] CMASK = 2'b00;
`endif

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] src_q, src_d;
  logic [LW-1:0]  len_q, len_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic           inp_pend_q, inp_pend_d;
  logic [2*N-1:0] wout_q, wout_d;
  logic [LW-1:0]  wlen_q, wlen_d;
  logic           rev_q, rev_d;
  logic           inp_q, inp_d;
  logic           err_q, err_d;

  logic [2*P-1:0] top;
  logic [2*P-3:0] top_short;
  logic           cls_rev, cls_inp, cls_err;
  logic [LW-1:0]  cls_plen;
  logic [2*N-1:0] cls_pay;

  logic [2*N-1:0] step_src, step_acc;
  logic           step_last;

  // True when h equals pfx with exactly one of its P digits removed.
  function automatic logic del_match(input logic [2*P-1:0] pfx, input logic [2*P-3:0] h);
    logic           hit;
    logic [2*P-3:0] cand;
    int             m;
    hit = 1'b0;
    for (int k = 0; k < P; k++) begin
      cand = '0;
      m = 0;
      for (int j = 0; j < P; j++) begin
        if (j != k) begin
          cand[2*(P-2-m) +: 2] = pfx[2*(P-1-j) +: 2];
          m = m + 1;
        end
      end
      if (cand == h) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin : classify
    int len_i;
    int strip;
    len_i = int'(len_q);
    top = '0;
    for (int k = 0; k < P; k++) begin
      for (int i = 0; i < N; i++) begin
        if (i == len_i - 1 - k) top[2*(P-1-k) +: 2] = src_q[2*i +: 2];
      end
    end
    top_short = top[2*P-1 -: 2*(P-1)];
    cls_rev = 1'b0;
    cls_inp = 1'b0;
    cls_err = 1'b0;
    strip   = 0;
    // Each class only applies when the word is long enough to hold its prefix.
    if (len_i > N) begin
      cls_err = 1'b1;
    end else if (len_i >= P && top == FWD_PREFIX) begin
      strip = P;
    end else if (len_i >= P-1 && del_match(FWD_PREFIX, top_short)) begin
      cls_inp = 1'b1;
      strip   = P-1;
    end else if (len_i >= P && top == REV_PREFIX) begin
      cls_rev = 1'b1;
      strip   = P;
    end else if (len_i >= P-1 && del_match(REV_PREFIX, top_short)) begin
      cls_rev = 1'b1;
      cls_inp = 1'b1;
      strip   = P-1;
    end else begin
      cls_err = 1'b1;
    end
    cls_plen = cls_err ? '0 : len_q - LW'(strip);
    cls_pay  = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(cls_plen)) cls_pay[2*i +: 2] = src_q[2*i +: 2];
    end
  end

  // Shifting source LSB digits into the accumulator LSB lands source digit i at plen-1-i.
  always_comb begin : reverse_step
    step_src = src_q;
    step_acc = acc_q;
    for (int j = 0; j < DPC; j++) begin
      if (int'(cnt_q) + j < int'(len_q)) begin
        step_acc = {step_acc[2*N-3:0], step_src[1:0] ^ CMASK};
        step_src = step_src >> 2;
      end
    end
    step_last = (int'(cnt_q) + DPC >= int'(len_q));
  end

  always_comb begin : fsm
    state_d    = state_q;
    src_d      = src_q;
    len_d      = len_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    inp_pend_d = inp_pend_q;
    wout_d     = wout_q;
    wlen_d     = wlen_q;
    rev_d      = rev_q;
    inp_d      = inp_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          src_d   = word_in;
          len_d   = word_in_len;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (cls_rev && cls_plen != '0) begin
          src_d      = cls_pay;
          len_d      = cls_plen;
          acc_d      = '0;
          cnt_d      = '0;
          inp_pend_d = cls_inp;
          state_d    = S_REVERSE;
        end else begin
          wout_d  = cls_pay;
          wlen_d  = cls_plen;
          rev_d   = cls_rev;
          inp_d   = cls_inp;
          err_d   = cls_err;
          state_d = S_OUT;
        end
      end
      S_REVERSE: begin
        src_d = step_src;
        acc_d = step_acc;
        if (step_last) begin
          cnt_d   = '0;
          wout_d  = step_acc;
          wlen_d  = len_q;
          rev_d   = 1'b1;
          inp_d   = inp_pend_q;
          err_d   = 1'b0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + LW'(DPC);
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      inp_pend_q <= 1'b0;
      wout_q     <= '0;
      wlen_q     <= '0;
      rev_q      <= 1'b0;
      inp_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      inp_pend_q <= inp_pend_d;
      wout_q     <= wout_d;
      wlen_q     <= wlen_d;
      rev_q      <= rev_d;
      inp_q      <= inp_d;
      err_q      <= err_d;
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = (state_q == S_OUT);
  assign busy           = (state_q != S_IDLE);
  assign word_out       = wout_q;
  assign word_out_len   = wlen_q;
  assign reverse_needed = rev_q;
  assign in_prefix      = inp_q;
  assign prefix_err     = err_q;

endmodule

// File: tb/tb_prefix_orient_unit.sv
// Scoreboard bench for prefix_orient_unit at N=8, P=2, DPC=2; expectations pushed on send, popped on output.
// Covers the documented cases, backpressure hold, mid-reverse reset abort and randomised words.
module tb_prefix_orient_unit;

  typedef struct {
    logic [15:0] w;
    logic [3:0]  len;
    bit          rev;
    bit          inp;
    bit          err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] word_in;
  logic [3:0]  word_in_len;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_out;
  logic [3:0]  word_out_len;
  logic        reverse_needed;
  logic        in_prefix;
  logic        prefix_err;
  logic        busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  exp_t sb[$];

  prefix_orient_unit #(
    .N(8), .P(2), .FWD_PREFIX(4'b0100), .REV_PREFIX(4'b1011), .DPC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .word_in(word_in), .word_in_len(word_in_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .word_out(word_out), .word_out_len(word_out_len),
    .reverse_needed(reverse_needed), .in_prefix(in_prefix),
    .prefix_err(prefix_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] w, input int len, input bit rev,
                              input bit inp, input bit err, input int lat);
    exp_t e;
    e.w = w; e.len = 4'(len); e.rev = rev; e.inp = inp; e.err = err; e.lat = lat;
    return e;
  endfunction

  // Reference: digits read first-to-last, prefix "14" forward / "23" reverse, DPC=2.
  function automatic exp_t model(input logic [15:0] w, input int len);
    exp_t       e;
    int         strip;
    int         plen;
    logic [1:0] d0, d1, cm;
    cm = 2'b00;
`ifdef REVCOMP_EN
    cm = 2'b01;
`endif
    e.w = '0; e.len = '0; e.rev = 0; e.inp = 0; e.err = 0; e.lat = 2;
    strip = 0;
    if (len < 1 || len > 8) begin
      e.err = 1;
    end else begin
      d0 = w[2*(len-1) +: 2];
      d1 = 2'b00;
      if (len >= 2) d1 = w[2*(len-2) +: 2];
      if (len >= 2 && d0 == 2'b01 && d1 == 2'b00) strip = 2;
      else if (d0 == 2'b01 || d0 == 2'b00) begin e.inp = 1; strip = 1; end
      else if (len >= 2 && d0 == 2'b10 && d1 == 2'b11) begin e.rev = 1; strip = 2; end
      else begin e.rev = 1; e.inp = 1; strip = 1; end
      plen = len - strip;
      e.len = 4'(plen);
      for (int k = 0; k < plen; k++) begin
        if (e.rev) e.w[2*(plen-1-k) +: 2] = w[2*k +: 2] ^ cm;
        else       e.w[2*k +: 2] = w[2*k +: 2];
      end
      if (e.rev) e.lat = 2 + (plen + 1) / 2;
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] w, input int len, input bit push, input exp_t e);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk("send_ready", in_ready, 1);
    word_in = w;
    word_in_len = 4'(len);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   k;
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    chk("out_valid_seen", out_valid, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("latency", cyc - acc_cyc + 1, e.lat);
      chk("word_out", word_out, e.w);
      chk("word_out_len", word_out_len, e.len);
      chk("reverse_needed", reverse_needed, e.rev);
      chk("in_prefix", in_prefix, e.inp);
      chk("prefix_err", prefix_err, e.err);
      chk("busy_out", busy, 1);
      chk("in_ready_out", in_ready, 0);
      repeat (hold) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_word", word_out, e.w);
        chk("hold_len", word_out_len, e.len);
        chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_word_hold", word_out, e.w);
      chk("post_rev_hold", reverse_needed, e.rev);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          len;
    int          sel;
    bit          seen;
    logic [15:0] rev2_exp;
    logic [15:0] rev4_exp;
`ifdef REVCOMP_EN
    rev2_exp = 16'h00D0;
    rev4_exp = 16'h0003;
`else
    rev2_exp = 16'h0085;
    rev4_exp = 16'h0006;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    word_in = '0; word_in_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_len", word_out_len, 0);
    chk("rst_flags", {reverse_needed, in_prefix, prefix_err}, 0);
    rst = 1'b0;

    send(16'h04B6, 6, 1, mk(16'h00B6, 4, 0, 0, 0, 2)); collect(0);
    send(16'h0B52, 6, 1, mk(rev2_exp, 4, 1, 0, 0, 4)); collect(0);
    send(16'h002B, 4, 1, mk(16'h002B, 3, 0, 1, 0, 2)); collect(0);
    send(16'h0039, 3, 1, mk(rev4_exp, 2, 1, 1, 0, 3)); collect(0);
    send(16'h04B6, 0, 1, mk(16'h0000, 0, 0, 0, 1, 2)); collect(0);
    send(16'h04B6, 9, 1, mk(16'h0000, 0, 0, 0, 1, 2)); collect(0);
    send(16'h000B, 2, 1, mk(16'h0000, 0, 1, 0, 0, 2)); collect(0);

    // Backpressure: result must stay put while out_ready is low.
    send(16'h0B52, 6, 1, mk(rev2_exp, 4, 1, 0, 0, 4)); collect(5);

    // Reset during REVERSE aborts the word with no output.
    send(16'hB6B6, 8, 0, mk(16'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_word_out", word_out, 0);
    chk("abort_flags", {reverse_needed, in_prefix, prefix_err}, 0);
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("abort_no_valid", seen, 0);
    send(16'h0039, 3, 1, mk(rev4_exp, 2, 1, 1, 0, 3)); collect(0);

    for (int r = 0; r < 10; r++) begin
      w = 16'($urandom);
      len = $urandom_range(0, 8);
      sel = $urandom_range(0, 2);
      if (len >= 2 && sel == 0) begin
        w[2*(len-1) +: 2] = 2'b01; w[2*(len-2) +: 2] = 2'b00;
      end else if (len >= 2 && sel == 1) begin
        w[2*(len-1) +: 2] = 2'b10; w[2*(len-2) +: 2] = 2'b11;
      end
      send(w, len, 1, model(w, len));
      collect(r % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
